// File: rtl/pipe_multdiv_unit_if.sv
// Request/result handshake bundle for pipe_multdiv_unit.
// The master (execute stage) issues requests; the slave (unit) returns tagged results.
interface pipe_multdiv_unit_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic             op_mult;
   logic             op_div;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] out_tag;
   logic             exception;
   logic             busy;

   modport master (
      output flush, in_valid, op_mult, op_div, operand_a, operand_b, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag, exception, busy
   );

   modport slave (
      input  flush, in_valid, op_mult, op_div, operand_a, operand_b, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag, exception, busy
   );
endinterface

// File: rtl/pipe_multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Results are tagged, held under backpressure and flagged on overflow or divide-by-zero.
module pipe_multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   pipe_multdiv_unit_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dvs;
   logic               r_neg;
   logic               r_ovf;
   logic               r_dz;
   logic [TAG_W-1:0]   r_tag;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic [TAG_W-1:0]   r_out_tag;
   logic               r_exc;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH-1:0] w_add;
   logic [2*WIDTH-1:0] w_acc_nx;
   logic               w_mul_ovf;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quo_nx;
   logic [WIDTH-1:0]   w_quo_signed;

   assign w_accept = (r_state == S_IDLE) && bus.in_valid && (bus.op_mult || bus.op_div) && !bus.flush;
   assign w_last   = (r_cnt == CNT_W'(1));
   assign w_a_mag  = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
   assign w_b_mag  = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;

   // Final multiplier bit carries negative weight, so it is subtracted.
   assign w_add     = r_mplier[0] ? (w_last ? -r_mcand : r_mcand) : '0;
   assign w_acc_nx  = r_acc + w_add;
   assign w_mul_ovf = (w_acc_nx[2*WIDTH-1:WIDTH] != {WIDTH{w_acc_nx[WIDTH-1]}});

   assign w_rem_sh     = {r_rem, r_quo[WIDTH-1]};
   assign w_diff       = w_rem_sh - {1'b0, r_dvs};
   assign w_qbit       = ~w_diff[WIDTH];
   assign w_rem_nx     = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_nx     = {r_quo[WIDTH-2:0], w_qbit};
   assign w_quo_signed = r_neg ? -w_quo_nx : w_quo_nx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
         r_dz        <= 1'b0;
         r_tag       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_out_tag   <= '0;
         r_exc       <= 1'b0;
      end else if (bus.flush) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tag <= bus.in_tag;
                  r_cnt <= CNT_W'(WIDTH);
                  if (bus.op_mult) begin
                     r_state  <= S_MULT;
                     r_acc    <= '0;
                     r_mcand  <= {{WIDTH{bus.operand_a[WIDTH-1]}}, bus.operand_a};
                     r_mplier <= bus.operand_b;
                  end else begin
                     r_state <= S_DIV;
                     r_neg   <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                     r_rem   <= '0;
                     r_quo   <= w_a_mag;
                     r_dvs   <= w_b_mag;
                     r_ovf   <= (bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.operand_b == '1);
                     r_dz    <= (bus.operand_b == '0);
                     if (bus.operand_b == '0)
                        r_cnt <= CNT_W'(1);
                  end
               end
            end
            S_MULT: begin
               r_acc    <= w_acc_nx;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - CNT_W'(1);
               if (w_last) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_acc_nx[WIDTH-1:0];
                  r_exc       <= w_mul_ovf;
                  r_out_tag   <= r_tag;
               end
            end
            S_DIV: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_dz) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= '0;
                  r_exc       <= 1'b1;
                  r_out_tag   <= r_tag;
               end else begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  if (w_last) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_quo_signed;
                     r_exc       <= r_ovf;
                     r_out_tag   <= r_tag;
                  end
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.out_tag   = r_out_tag;
   assign bus.exception = r_exc;

endmodule

// File: tb/tb_pipe_multdiv_unit.sv
// Directed bench for pipe_multdiv_unit at WIDTH=32 with hand-computed results.
module tb_pipe_multdiv_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc;
   logic seen;

   always #5 clk = ~clk;

   pipe_multdiv_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();

   pipe_multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.op_mult   = m;
      bus.op_div    = d;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.in_tag    = tag;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.op_mult  = 1'b0;
      bus.op_div   = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (bus.out_valid) break;
      end
      check("out_valid_within_bound", bus.out_valid, 1);
   endtask

   task automatic op_check(input string name, input logic m, input logic d, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input int lat,
                           input logic [31:0] res, input logic exc);
      int c;
      issue(m, d, a, b, tag);
      check({name, "_busy"}, bus.busy, 1);
      wait_done(c);
      check({name, "_latency"}, c, lat);
      check({name, "_result"}, bus.result, res);
      check({name, "_tag"}, bus.out_tag, tag);
      check({name, "_exc"}, bus.exception, exc);
      check({name, "_in_ready_done"}, bus.in_ready, 0);
      @(posedge clk);
      #1;
      check({name, "_in_ready_after"}, bus.in_ready, 1);
      check({name, "_valid_after"}, bus.out_valid, 0);
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op_mult   = 1'b0;
      bus.op_div    = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_out_tag", bus.out_tag, 0);
      check("rst_exc", bus.exception, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      op_check("mul_7_m3", 1, 0, 32'd7, 32'hFFFFFFFD, 5'd9, 32, 32'hFFFFFFEB, 0);
      op_check("mul_ovf", 1, 0, 32'h40000000, 32'd4, 5'd1, 32, 32'h00000000, 1);
      op_check("mul_m1_m1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32, 32'h00000001, 0);
      op_check("both_ops_mult", 1, 1, 32'd6, 32'd5, 5'd3, 32, 32'd30, 0);
      op_check("div_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2, 5'd4, 32, 32'hFFFFFFFD, 0);
      op_check("div_by_zero", 0, 1, 32'd5, 32'd0, 5'd5, 1, 32'h00000000, 1);
      op_check("div_ovf", 0, 1, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32, 32'h80000000, 1);

      // Request with no op bit set is ignored.
      @(negedge clk);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("noop_ignored", bus.busy, 0);
      bus.in_valid = 1'b0;

      // Backpressure
      bus.out_ready = 1'b0;
      issue(0, 1, 32'd1000, 32'hFFFFFFFD, 5'd12);
      wait_done(cyc);
      check("bp_latency", cyc, 32);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.op_mult   = 1'b1;
         bus.operand_a = 32'd1;
         bus.operand_b = 32'd1;
         bus.in_tag    = 5'd1;
         @(posedge clk);
         #1;
         check("bp_valid", bus.out_valid, 1);
         check("bp_result", bus.result, 32'hFFFFFEB3);
         check("bp_tag", bus.out_tag, 12);
         check("bp_exc", bus.exception, 0);
         check("bp_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.op_mult   = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_in_ready", bus.in_ready, 1);
      check("bp_result_kept", bus.result, 32'hFFFFFEB3);
      @(posedge clk);
      #1;
      check("bp_no_accept", bus.busy, 0);

      // Flush 10 cycles into a multiply, with a new request in the same cycle
      issue(1, 0, 32'd123, 32'd456, 5'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op_mult   = 1'b1;
      bus.operand_a = 32'd5;
      bus.operand_b = 32'd5;
      bus.in_tag    = 5'd7;
      @(posedge clk);
      #1;
      check("flush_busy", bus.busy, 0);
      check("flush_valid", bus.out_valid, 0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.op_mult  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         seen = seen | bus.out_valid | bus.busy;
      end
      check("flush_quiet", seen, 0);

      // Flush in IDLE overrides accept
      @(negedge clk);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.op_div   = 1'b1;
      @(posedge clk);
      #1;
      check("flush_idle_no_accept", bus.busy, 0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.op_div   = 1'b0;

      op_check("mul_after_flush", 1, 0, 32'd6, 32'd7, 5'd4, 32, 32'd42, 0);

      // Async reset mid-divide
      issue(0, 1, 32'd1000, 32'd3, 5'd2);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_result", bus.result, 0);
      check("arst_tag", bus.out_tag, 0);
      check("arst_exc", bus.exception, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      op_check("div_100_7", 0, 1, 32'd100, 32'd7, 5'd5, 32, 32'd14, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_multdiv_unit.md
Name: pipe_multdiv_unit

Overview:
- Parametrised iterative signed multiply/divide unit for the 5-stage pipeline. It sits beside the ALU in the execute stage.
- Accepts one operation per valid/ready handshake, tagged with its destination register. Returns the result through a second valid/ready handshake so that the hazard logic can stall dependents.
- Adds a width parameter, overflow/divide-by-zero exception reporting, result backpressure and flush, none of which the single-cycle ALU path has.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- TAG_W, 5, width of the destination tag carried through (register number).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high only in IDLE.
- op_mult  in  1  request is multiply.
- op_div  in  1  request is divide.
- operand_a  in  WIDTH  multiplicand / dividend, two's complement.
- operand_b  in  WIDTH  multiplier / divisor, two's complement.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  product low half or quotient.
- out_tag  out  TAG_W  tag of the result.
- exception  out  1  overflow or divide-by-zero flag for the result.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, MULT, DIV, DONE.
- Reset (reset=0, async):
  - State goes to IDLE; internal counter and accumulators clear.
  - out_valid=0, result=0, out_tag=0, exception=0, busy=0, in_ready=1.
  - Reset during MULT/DIV/DONE discards the operation.
- Accept condition: in_valid & in_ready & (op_mult | op_div) on a rising edge E0.
  - operand_a, operand_b, in_tag and op are captured.
  - If both op bits are set, multiply wins.
  - in_valid with neither op bit set is ignored; state stays IDLE.
- in_ready = (state==IDLE), combinational from state. No accept in the same cycle a result is taken.
- MULT:
  - Signed shift-add, one bit per cycle, counter loaded with WIDTH at E0.
  - DONE is entered at edge E0+WIDTH; out_valid=1 from that edge.
  - result = low WIDTH bits of the 2·WIDTH product.
  - exception=1 iff the upper WIDTH bits are not the sign-extension of result bit WIDTH-1.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle, WIDTH cycles. DONE is entered at edge E0+WIDTH.
  - Quotient is truncated toward zero; its sign is sign(a) XOR sign(b). The remainder is discarded.
  - Divisor 0: DONE at E0+1, result=0, exception=1.
  - a = most-negative and b = -1: result = most-negative, exception=1, full WIDTH latency.
  - Otherwise exception=0.
- DONE:
  - result, out_tag and exception are registered and held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid→0 and state→IDLE. result, out_tag and exception keep their values.
- flush: on an edge with flush=1, state→IDLE and out_valid→0, regardless of state.
  - flush overrides accept in the same cycle: a request presented with flush is not captured.
- busy = (state!=IDLE). All outputs except in_ready and busy are registered.
- Counter width is clog2(WIDTH+1). No wrap: the counter stops at 0 on entering DONE.

Test Plan:
- WIDTH=32, mult a=7, b=-3, tag=9, out_ready=1 → out_valid exactly 32 cycles after accept; result=0xFFFFFFEB, out_tag=9, exception=0; in_ready high the following cycle.
- Mult a=0x40000000, b=4 → result=0x00000000, exception=1. Then mult a=-1, b=-1 → result=1, exception=0.
- Div a=-7, b=2 → result=0xFFFFFFFD after 32 cycles. Div a=5, b=0 → out_valid 1 cycle after accept, result=0, exception=1. Div a=0x80000000, b=-1 → result=0x80000000, exception=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result, out_tag and exception stable, in_ready=0, a new in_valid is not accepted. Raise out_ready → IDLE next edge.
- flush asserted 10 cycles into a mult, with in_valid also high that cycle → IDLE, out_valid never asserts, that request is not captured. Next request behaves normally.
- Drop reset low mid-div (async, between edges) → outputs immediately go to reset values, in_ready=1. After release, div a=100, b=7 → result=14.
